reg_wb_arbiter: RTL

Write-side front end for the 32x32 register file. Merges single-cycle pipeline write-backs with results from multi-cycle units (multiplier/divider) that arrive through a valid/ready handshake, and buffers the latter in a small FIFO. Drives the register file's `regwrite_i` / `rdaddr_i` / `rddata_i` from registered outputs. Exposes a pending-address query so the hazard unit can stall dependent reads.

---
 rtl/reg_wb_arbiter_if.sv | 42 ++++
 rtl/reg_wb_arbiter.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/reg_wb_arbiter_if.sv
// reg_wb_arbiter_if
// Bundles the register-file write-back front end's bus signals.
//   Pipeline write-back : pipe_we_i, pipe_addr_i, pipe_data_i
//   Multi-cycle results : mc_valid_i, mc_addr_i, mc_data_i, mc_ready_o
//   Register-file write : regwrite_o, rdaddr_o, rddata_o
//   Hazard unit         : query_addr_i, query_hit_o, pending_o, stall_o
// Signal suffixes are from the arbiter's point of view.
// The slave modport is taken by the arbiter; master by the surrounding logic.
interface reg_wb_arbiter_if;
  logic        pipe_we_i;
  logic [4:0]  pipe_addr_i;
  logic [31:0] pipe_data_i;
  logic        mc_valid_i;
  logic        mc_ready_o;
  logic [4:0]  mc_addr_i;
  logic [31:0] mc_data_i;
  logic        regwrite_o;
  logic [4:0]  rdaddr_o;
  logic [31:0] rddata_o;
  logic [4:0]  query_addr_i;
  logic        query_hit_o;
  logic        pending_o;
  logic        stall_o;

  modport slave (
    input  pipe_we_i, pipe_addr_i, pipe_data_i,
    input  mc_valid_i, mc_addr_i, mc_data_i,
    output mc_ready_o,
    output regwrite_o, rdaddr_o, rddata_o,
    input  query_addr_i,
    output query_hit_o, pending_o, stall_o
  );

  modport master (
    output pipe_we_i, pipe_addr_i, pipe_data_i,
    output mc_valid_i, mc_addr_i, mc_data_i,
    input  mc_ready_o,
    input  regwrite_o, rdaddr_o, rddata_o,
    output query_addr_i,
    input  query_hit_o, pending_o, stall_o
  );
endinterface

// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter
// Write-side front end of the 32x32 register file. Single-cycle pipeline
// write-backs take priority; multi-cycle results are buffered in a FIFO and
// drained on cycles the pipeline leaves the write port free. A starvation
// counter forces a one-cycle stall so the FIFO head eventually drains.
// Ports:
//   clk_i   : clock, rising edge
//   rst_n_i : asynchronous reset, active-low
//   bus     : reg_wb_arbiter_if.slave (pipeline, multi-cycle handshake,
//             register-file write port, hazard query)
// Parameters:
//   DEPTH        : FIFO entries, power of 2, >= 2
//   STARVE_LIMIT : pipeline-write cycles with FIFO pending before a stall (1..255)
// Build option:
//   WB_ZERO_FILTER_EN : suppress writes to register 0 and ignore
//                       zero-address entries in the pending query.
module reg_wb_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input logic            clk_i,
  input logic            rst_n_i,
  reg_wb_arbiter_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    starve_q, starve_d;
  logic          stall_q, stall_d;
  logic          regwrite_q, regwrite_d;
  logic [4:0]    rdaddr_q, rdaddr_d;
  logic [31:0]   rddata_q, rddata_d;

  // Entry storage is not reset; validity is tracked by the pointers/count.
  logic [4:0]    addr_mem [DEPTH];
  logic [31:0]   data_mem [DEPTH];

  logic          full, empty, push, pop, starve_cond, hit;
  logic [8:0]    starve_inc;
  logic [PW-1:0] offset;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = bus.mc_valid_i && !full;
  assign pop   = !bus.pipe_we_i && !empty;

  assign bus.mc_ready_o  = !full;
  assign bus.pending_o   = !empty;
  assign bus.stall_o     = stall_q;
  assign bus.regwrite_o  = regwrite_q;
  assign bus.rdaddr_o    = rdaddr_q;
  assign bus.rddata_o    = rddata_q;
  assign bus.query_hit_o = hit;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Write-port arbitration: pipeline first, then FIFO head, else idle with
  // address/data held.
  always_comb begin
    regwrite_d = 1'b0;
    rdaddr_d   = rdaddr_q;
    rddata_d   = rddata_q;
    if (bus.pipe_we_i) begin
`ifdef WB_ZERO_FILTER_EN
      regwrite_d = |bus.pipe_addr_i;
`else
      regwrite_d = 1'b1;
`endif
      rdaddr_d   = bus.pipe_addr_i;
      rddata_d   = bus.pipe_data_i;
    end else if (pop) begin
`ifdef WB_ZERO_FILTER_EN
      regwrite_d = |addr_mem[rd_ptr_q];
`else
      regwrite_d = 1'b1;
`endif
      rdaddr_d   = addr_mem[rd_ptr_q];
      rddata_d   = data_mem[rd_ptr_q];
    end
  end

  // Starvation: the stall is registered on the edge where the counter would
  // reach the limit, so it shows up the cycle after the last starved write.
  always_comb begin
    starve_cond = bus.pipe_we_i && !empty;
    starve_inc  = {1'b0, starve_q} + 9'd1;
    starve_d    = 8'd0;
    stall_d     = 1'b0;
    if (starve_cond) begin
      if (starve_inc == 9'(STARVE_LIMIT)) stall_d = 1'b1;
      else                                 starve_d = starve_inc[7:0];
    end
  end

  // An entry is valid when its distance from the read pointer is below the
  // count; the head being popped this cycle is still counted.
  always_comb begin
    hit    = 1'b0;
    offset = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset = PW'(i) - rd_ptr_q;
`ifdef WB_ZERO_FILTER_EN
      if ((CW'(offset) < count_q) && (addr_mem[i] == bus.query_addr_i) && (|addr_mem[i]))
        hit = 1'b1;
`else
      if ((CW'(offset) < count_q) && (addr_mem[i] == bus.query_addr_i))
        hit = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      starve_q   <= '0;
      stall_q    <= 1'b0;
      regwrite_q <= 1'b0;
      rdaddr_q   <= '0;
      rddata_q   <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      starve_q   <= starve_d;
      stall_q    <= stall_d;
      regwrite_q <= regwrite_d;
      rdaddr_q   <= rdaddr_d;
      rddata_q   <= rddata_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      addr_mem[wr_ptr_q] <= bus.mc_addr_i;
      data_mem[wr_ptr_q] <= bus.mc_data_i;
    end
  end
endmodule
